// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : State encoding, default limits and sizing helper shared by the
//            instruction/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    localparam int c_TIMEOUT_DEF = 15;
    localparam int c_STREAK_DEF  = 4;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one single-ported memory between instruction fetch and
//            data load/store, with wait-timeout abort and fetch-starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEF,
    parameter int STREAK  = c_STREAK_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_valid,
    output logic [15:0] if_rdata,
    input  logic        d_re,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        mem_re,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_d,
    output logic        err
);

    localparam int WAIT_W = cnt_width(TIMEOUT);
    localparam int STRK_W = cnt_width(STREAK);
    localparam logic [WAIT_W-1:0] c_WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [STRK_W-1:0] c_STRK_MAX = STRK_W'(STREAK);

    logic [1:0]        state_q,      state_d;
    logic [WAIT_W-1:0] wait_q,       wait_d;
    logic [STRK_W-1:0] streak_q,     streak_d;
    logic              mem_re_q,     mem_re_d;
    logic              mem_we_q,     mem_we_d;
    logic [15:0]       mem_addr_q,   mem_addr_d;
    logic [15:0]       mem_wdata_q,  mem_wdata_d;
    logic [15:0]       if_rdata_q,   if_rdata_d;
    logic [15:0]       d_rdata_q,    d_rdata_d;
    logic              serve_data_q, serve_data_d;
    logic              abort_q,      abort_d;

    logic w_data_pend;
    logic w_grant_data;
    logic w_grant_fetch;
    logic w_busy;
    logic w_timeout;
    logic w_finish;

    // Data wins unless it has already starved a waiting fetch for STREAK grants.
    assign w_data_pend   = d_re | d_we;
    assign w_grant_data  = (state_q == c_ST_IDLE) & w_data_pend &
                           ((streak_q < c_STRK_MAX) | ~if_req);
    assign w_grant_fetch = (state_q == c_ST_IDLE) & ~w_grant_data & if_req;
    assign w_busy        = (state_q == c_ST_FETCH) | (state_q == c_ST_DATA);
    assign w_timeout     = (wait_q == c_WAIT_MAX);
    assign w_finish      = w_busy & (mem_ready | w_timeout);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= c_ST_IDLE;
            wait_q       <= '0;
            streak_q     <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            serve_data_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            streak_q     <= streak_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            serve_data_q <= serve_data_d;
            abort_q      <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_grant_data) begin
                    state_d = c_ST_DATA;
                end else if (w_grant_fetch) begin
                    state_d = c_ST_FETCH;
                end
            end
            c_ST_FETCH, c_ST_DATA: begin
                if (w_finish) begin
                    state_d = c_ST_RESP;
                end
            end
            c_ST_RESP: state_d = c_ST_IDLE;
            default:   state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        wait_d       = wait_q;
        streak_d     = streak_q;
        mem_re_d     = mem_re_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        serve_data_d = serve_data_q;
        abort_d      = abort_q;
        if (w_grant_data || w_grant_fetch) begin
            // A combined read+write request is performed as a store.
            mem_addr_d   = w_grant_data ? d_addr : if_addr;
            mem_wdata_d  = w_grant_data ? d_wdata : 16'h0000;
            mem_we_d     = w_grant_data & d_we;
            mem_re_d     = w_grant_fetch | (w_grant_data & ~d_we);
            serve_data_d = w_grant_data;
            abort_d      = 1'b0;
            wait_d       = '0;
            if (w_grant_data && if_req) begin
                streak_d = (streak_q < c_STRK_MAX) ? streak_q + 1'b1 : streak_q;
            end else begin
                streak_d = '0;
            end
        end else if (w_busy) begin
            if (mem_ready) begin
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
                if (serve_data_q) begin
                    d_rdata_d = mem_rdata;
                end else begin
                    if_rdata_d = mem_rdata;
                end
            end else if (w_timeout) begin
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
                abort_d  = 1'b1;
                if (serve_data_q) begin
                    d_rdata_d = 16'h0000;
                end else begin
                    if_rdata_d = 16'h0000;
                end
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    always_comb begin
        if_valid = (state_q == c_ST_RESP) & ~serve_data_q;
        d_done   = (state_q == c_ST_RESP) &  serve_data_q;
        err      = (state_q == c_ST_RESP) &  abort_q;
    end

    assign stall_if  = if_req & ~if_valid;
    assign stall_d   = w_data_pend & ~d_done;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, meaning max wait cycles for mem_ready before abort (4-bit counter).
REQ-002 Parameter STREAK, default 4, meaning max consecutive data grants while fetch pending.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  fetch request, held until if_valid.
REQ-006 if_addr  input  16  fetch address.
REQ-007 if_valid  output  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  output  16  fetched instruction, valid with if_valid.
REQ-009 d_re, d_we  input  1 each  data read/write request from decode (Mem_re/Mem_we), held until d_done.
REQ-010 d_addr, d_wdata  input  16 each  data address / store data.
REQ-011 d_done  output  1  one-cycle data completion pulse.
REQ-012 d_rdata  output  16  load data, valid with d_done.
REQ-013 mem_re, mem_we  output  1 each  registered memory strobes.
REQ-014 mem_addr, mem_wdata  output  16 each  registered memory address/data.
REQ-015 mem_ready  input  1  memory completion; mem_rdata valid same cycle.
REQ-016 mem_rdata  input  16  memory read data.
REQ-017 stall_if, stall_d  output  1 each  combinational stalls: if_req&~if_valid, (d_re|d_we)&~d_done.
REQ-018 err  output  1  one-cycle pulse on timeout or abort.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, DATA, RESP.
REQ-020 IDLE: data pending and (streak<STREAK or ~if_req) -> DATA; else if_req -> FETCH; else stay.
REQ-021 On grant, mem_addr/mem_wdata/mem_re/mem_we SHALL be latched from requester and appear the cycle after grant; held constant until completion.
REQ-022 d_re&d_we together SHALL be treated as write (mem_we=1, mem_re=0).
REQ-023 FETCH/DATA: mem_ready -> drop strobes, latch mem_rdata into if_rdata/d_rdata, go RESP.
REQ-024 RESP SHALL last exactly one cycle, assert if_valid or d_done for the served requester, ignore all requests, then go IDLE.
REQ-025 Wait counter SHALL clear on grant, increment each FETCH/DATA cycle without mem_ready; reaching TIMEOUT -> drop strobes, rdata=16'h0000, err=1 in RESP alongside done/valid pulse.
REQ-026 mem_ready in the same cycle counter reaches TIMEOUT SHALL count as success, no err.
REQ-027 Streak counter SHALL increment on data grant when if_req=1, clear on fetch grant or data grant with if_req=0, saturate at STREAK.
REQ-028 Minimum transaction latency: request in IDLE at cycle N -> strobe at N+1 -> mem_ready at N+1 -> done pulse at N+2.
REQ-029 Write data SHALL never be altered mid-transaction even if d_wdata changes.

Reset
REQ-030 rst SHALL force IDLE, all outputs 0 (mem strobes, if_valid, d_done, err, rdata regs), counters 0, aborting any in-flight access with no done pulse.

Structure
REQ-031 State encoding and default TIMEOUT/STREAK constants SHALL live in the shared processor package.
REQ-032 Single module; wait/streak counters inline, no sub-module.

Verification
REQ-033 Load only: d_re=1, d_addr=16'h0040, mem_ready one cycle after strobe, mem_rdata=16'hBEEF -> d_done pulse, d_rdata=16'hBEEF, err=0.
REQ-034 Simultaneous if_req and d_we continuously, ready immediate -> 4 data grants then 1 fetch grant, repeating.
REQ-035 mem_ready never asserted, TIMEOUT=15 -> strobes drop after 15 wait cycles, d_done=1 and err=1 same cycle, rdata=16'h0000.
REQ-036 mem_ready exactly at cycle 15 -> success, err=0, rdata from memory.
REQ-037 rst asserted mid-DATA -> next cycle mem_we=0, FSM IDLE, no d_done; following if_req served normally.
REQ-038 Request held through RESP -> no re-grant during RESP; new grant only from IDLE cycle after.
